// File: rtl/rv_mem_arbiter.sv
// Shared memory bus arbiter between instruction fetch and load/store data ports.
// Define MEM_ARB_FAIRNESS_EN to bound fetch starvation to FAIR_LIMIT data grants.
module rv_mem_arbiter #(
  parameter int FAIR_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_f_cyc,
  input  logic [31:0] i_f_addr,
  output logic        o_f_ack,
  output logic [31:0] o_f_data,
  input  logic        i_d_cyc,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_sel,
  input  logic        i_d_we,
  output logic        o_d_ack,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_sel,
  output logic        o_mem_we,
  output logic        o_mem_cyc,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_F = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   granted_cyc;
  logic   arb_en;
  logic   fair_hit;

  if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_bad_fair_limit
    $error("rv_mem_arbiter: FAIR_LIMIT must be in 1..15");
  end

  // Arbitrate when idle, when the granted cycle is acked, or when its owner drops cyc.
  assign granted_cyc = (state_q == GNT_F) ? i_f_cyc :
                       (state_q == GNT_D) ? i_d_cyc : 1'b0;
  assign arb_en      = !granted_cyc || i_mem_ack;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] fair_cnt_q, fair_cnt_d;

  assign fair_hit = i_f_cyc && (fair_cnt_q == 4'(FAIR_LIMIT));

  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (arb_en) begin
      if (!i_f_cyc || state_d == GNT_F) fair_cnt_d = '0;
      else if (state_d == GNT_D)        fair_cnt_d = fair_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) fair_cnt_q <= '0;
    else            fair_cnt_q <= fair_cnt_d;
  end
`else
  assign fair_hit = 1'b0;
`endif

  // NOTE: asynchronous reset drops state_q to IDLE immediately, so the bus cycle
  // is cut without waiting for a clock edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (arb_en) begin
      if (i_d_cyc && !fair_hit) state_d = GNT_D;
      else if (i_f_cyc)         state_d = GNT_F;
      else                      state_d = IDLE;
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_sel   = '0;
    o_mem_we    = 1'b0;
    o_grant     = 2'b00;
    unique case (state_q)
      GNT_F: begin
        o_mem_addr = i_f_addr;
        o_mem_sel  = 4'hF;
        o_grant    = 2'b01;
      end
      GNT_D: begin
        o_mem_addr  = i_d_addr;
        o_mem_wdata = i_d_wdata;
        o_mem_sel   = i_d_sel;
        o_mem_we    = i_d_we;
        o_grant     = 2'b10;
      end
      default: ;
    endcase
  end

  // Acks reach only the current owner, and only while it still holds cyc.
  assign o_mem_cyc = granted_cyc;
  assign o_f_ack   = (state_q == GNT_F) && i_mem_ack && i_f_cyc;
  assign o_d_ack   = (state_q == GNT_D) && i_mem_ack && i_d_cyc;
  assign o_f_data  = i_mem_rdata;
  assign o_d_rdata = i_mem_rdata;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed self-checking bench for rv_mem_arbiter; expectations follow MEM_ARB_FAIRNESS_EN.
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_cyc, d_cyc, d_we, mem_ack;
  logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_sel;
  logic        f_ack, d_ack, mem_we, mem_cyc;
  logic [31:0] f_data, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  rv_mem_arbiter #(.FAIR_LIMIT(4)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_f_cyc    (f_cyc),
    .i_f_addr   (f_addr),
    .o_f_ack    (f_ack),
    .o_f_data   (f_data),
    .i_d_cyc    (d_cyc),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .i_d_sel    (d_sel),
    .i_d_we     (d_we),
    .o_d_ack    (d_ack),
    .o_d_rdata  (d_rdata),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_sel  (mem_sel),
    .o_mem_we   (mem_we),
    .o_mem_cyc  (mem_cyc),
    .i_mem_ack  (mem_ack),
    .i_mem_rdata(mem_rdata),
    .o_grant    (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    rst_n = 1'b0;
    f_cyc = 1'b1;  f_addr = 32'h0;
    d_cyc = 1'b1;  d_addr = 32'h0;  d_wdata = 32'h0;  d_sel = 4'h0;  d_we = 1'b0;
    mem_ack = 1'b1;  mem_rdata = 32'h1234_5678;

    // Reset held with both requesters active and a stray ack present.
    step();
    step();
    check("rst_grant",   32'(grant),   32'h0);
    check("rst_mem_cyc", 32'(mem_cyc), 32'h0);
    check("rst_f_ack",   32'(f_ack),   32'h0);
    check("rst_d_ack",   32'(d_ack),   32'h0);
    check("rst_f_data",  f_data,       32'h1234_5678);
    check("rst_d_rdata", d_rdata,      32'h1234_5678);
    rst_n = 1'b1;
    mem_ack = 1'b0;
    step();
    check("rel_grant",   32'(grant),   32'h2);
    check("rel_mem_cyc", 32'(mem_cyc), 32'h1);
    f_cyc = 1'b0;
    d_cyc = 1'b0;
    step();
    check("rel_idle", 32'(grant), 32'h0);

    // Single fetch, memory acks in the second granted cycle.
    f_cyc = 1'b1;  f_addr = 32'h100;
    step();
    check("f_grant",   32'(grant),   32'h1);
    check("f_mem_cyc", 32'(mem_cyc), 32'h1);
    check("f_addr",    mem_addr,     32'h100);
    check("f_we",      32'(mem_we),  32'h0);
    check("f_sel",     32'(mem_sel), 32'hF);
    check("f_wdata",   mem_wdata,    32'h0);
    check("f_wait_ack", 32'(f_ack),  32'h0);
    step();
    check("f_wait_ack2", 32'(f_ack), 32'h0);
    mem_ack = 1'b1;  mem_rdata = 32'hCAFE_F00D;
    #1;
    check("f_ack",    32'(f_ack), 32'h1);
    check("f_data",   f_data,     32'hCAFE_F00D);
    check("f_d_ack",  32'(d_ack), 32'h0);
    step();
    f_cyc = 1'b0;  mem_ack = 1'b0;
    #1;
    check("f_drop_cyc", 32'(mem_cyc), 32'h0);
    check("f_drop_ack", 32'(f_ack),   32'h0);
    step();
    check("f_idle", 32'(grant), 32'h0);

    // Data write with partial byte select.
    d_cyc = 1'b1;  d_addr = 32'h2000;  d_wdata = 32'hDEAD_BEEF;  d_sel = 4'b0011;  d_we = 1'b1;
    step();
    check("w_grant", 32'(grant),   32'h2);
    check("w_addr",  mem_addr,     32'h2000);
    check("w_wdata", mem_wdata,    32'hDEAD_BEEF);
    check("w_sel",   32'(mem_sel), 32'h3);
    check("w_we",    32'(mem_we),  32'h1);
    check("w_cyc",   32'(mem_cyc), 32'h1);
    mem_ack = 1'b1;
    #1;
    check("w_d_ack", 32'(d_ack), 32'h1);
    check("w_f_ack", 32'(f_ack), 32'h0);
    step();
    d_cyc = 1'b0;  d_we = 1'b0;  mem_ack = 1'b0;
    step();
    check("w_idle",     32'(grant), 32'h0);
    check("w_idle_addr", mem_addr,  32'h0);

    // Fetch abandoned before ack while data requests; late ack must not reach fetch.
    f_cyc = 1'b1;  f_addr = 32'h300;
    step();
    check("ab_f_grant", 32'(grant), 32'h1);
    check("ab_f_addr",  mem_addr,   32'h300);
    f_cyc = 1'b0;
    d_cyc = 1'b1;  d_addr = 32'h4000;  d_sel = 4'hF;  d_we = 1'b0;
    mem_ack = 1'b1;
    #1;
    check("ab_late_f_ack", 32'(f_ack),   32'h0);
    check("ab_drop_cyc",   32'(mem_cyc), 32'h0);
    step();
    mem_ack = 1'b0;
    #1;
    check("ab_d_grant", 32'(grant),   32'h2);
    check("ab_d_addr",  mem_addr,     32'h4000);
    check("ab_d_cyc",   32'(mem_cyc), 32'h1);
    check("ab_f_ack",   32'(f_ack),   32'h0);

    // Reset asserted mid-cycle while data owns the bus.
    #3;
    rst_n = 1'b0;
    mem_ack = 1'b1;
    #1;
    check("mr_mem_cyc", 32'(mem_cyc), 32'h0);
    check("mr_grant",   32'(grant),   32'h0);
    check("mr_d_ack",   32'(d_ack),   32'h0);
    d_cyc = 1'b0;  mem_ack = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    check("mr_idle", 32'(grant), 32'h0);

    // Continuous contention with zero-wait memory.
    f_cyc = 1'b1;  f_addr = 32'h500;
    d_cyc = 1'b1;  d_addr = 32'h6000;
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
`ifdef MEM_ARB_FAIRNESS_EN
      exp_g = (i % 5 == 4) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b10;
`endif
      check($sformatf("ct_grant_%0d", i), 32'(grant), 32'(exp_g));
      check($sformatf("ct_f_ack_%0d", i), 32'(f_ack), 32'(exp_g[0]));
    end
    f_cyc = 1'b0;  d_cyc = 1'b0;  mem_ack = 1'b0;
    step();
    check("ct_idle", 32'(grant), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
